// File: rtl/fir_mac_scheduler_if.sv
// Channel-sample, coefficient-port and filtered-result bundle between the
// per-channel sample sources, the FIR MAC scheduler and the resampler.
interface fir_mac_scheduler_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]    in_valid;
  logic [16*NUM_CH-1:0] in_data;
  logic                 coef_we;
  logic [4:0]           coef_addr;
  logic [15:0]          coef_wdata;
  logic                 coef_ready;
  logic                 out_valid;
  logic [2:0]           out_ch;
  logic [15:0]          out_data;
  logic [NUM_CH-1:0]    overrun;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
    input  coef_ready, out_valid, out_ch, out_data, overrun
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
    output coef_ready, out_valid, out_ch, out_data, overrun
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// One 16x16 unsigned MAC shared round-robin across NUM_CH channels, each with
// its own TAPS-deep sample history and a common programmable coefficient table.
module fir_mac_scheduler #(
  parameter int NUM_CH = 2,
  parameter int TAPS   = 10,
  parameter int ACC_W  = 36
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fir_mac_scheduler_if.slave bus_io
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW  = $clog2(TAPS);
  localparam int RW  = ACC_W - 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MAC   = 2'd2,
    ST_ROUND = 2'd3
  } state_t;

  function automatic logic [15:0] coef_default(input int idx);
    logic [15:0] val;
    case (idx)
      0, 9:    val = 16'd89;
      1, 8:    val = 16'd795;
      2, 7:    val = 16'd2665;
      3, 6:    val = 16'd5374;
      4, 5:    val = 16'd7461;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] overrun_q;
  logic [15:0]       cap_q  [NUM_CH];
  logic [15:0]       hist_q [NUM_CH][TAPS];
  logic [TW-1:0]     wptr_q [NUM_CH];
  logic [15:0]       coef_q [TAPS];
  logic [2:0]        prio_q;
  logic [2:0]        ch_q;
  logic [15:0]       work_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TW-1:0]     k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic [2:0]        out_ch_q, out_ch_d;
  logic [15:0]       out_data_q, out_data_d;

  logic              grant_valid_s;
  logic [2:0]        grant_ch_s;
  logic [3:0]        cand_s;
  logic              grant_en_s;
  logic              load_en_s;
  logic              mac_en_s;
  logic              round_en_s;
  logic              last_tap_s;
  logic              coef_ready_s;
  logic              coef_wr_s;
  logic [CHW-1:0]    ch_idx_s;
  logic [TW-1:0]     rd_idx_s;
  logic [31:0]       prod_s;
  logic [RW-1:0]     round_s;
  logic [15:0]       sat_s;

  assign ch_idx_s     = ch_q[CHW-1:0];
  assign last_tap_s   = (k_q == TW'(TAPS - 1));
  assign coef_ready_s = (state_q == ST_IDLE) && (pending_q == '0);
  assign coef_wr_s    = bus_io.coef_we && coef_ready_s &&
                        ({1'b0, bus_io.coef_addr} < 6'(TAPS));

  // Round-robin pick: scan from the pointer; lowest offset wins, so iterate downwards.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_ch_s    = 3'd0;
    cand_s        = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_s        = {1'b0, prio_q} + 4'(i);
      cand_s        = (cand_s >= 4'(NUM_CH)) ? (cand_s - 4'(NUM_CH)) : cand_s;
      grant_ch_s    = pending_q[cand_s[CHW-1:0]] ? cand_s[2:0] : grant_ch_s;
      grant_valid_s = grant_valid_s | pending_q[cand_s[CHW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_MAC;
      ST_MAC: begin
        if (last_tap_s) begin
          state_d = ST_ROUND;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_ROUND: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_en_s = (state_q == ST_IDLE) && grant_valid_s;
    load_en_s  = (state_q == ST_LOAD);
    mac_en_s   = (state_q == ST_MAC);
    round_en_s = (state_q == ST_ROUND);
  end

  // A strobe on the channel being granted refills pending without counting as a loss.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= '0;
      overrun_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cap_q[c] <= 16'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus_io.in_valid[c]) begin
          pending_q[c] <= 1'b1;
          cap_q[c]     <= bus_io.in_data[16*c +: 16];
          if (pending_q[c] && !(grant_en_s && (grant_ch_s == 3'(c)))) begin
            overrun_q[c] <= 1'b1;
          end
        end else if (grant_en_s && (grant_ch_s == 3'(c))) begin
          pending_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_q <= 3'd0;
      ch_q   <= 3'd0;
      work_q <= 16'd0;
    end else if (grant_en_s) begin
      prio_q <= (grant_ch_s == 3'(NUM_CH - 1)) ? 3'd0 : (grant_ch_s + 3'd1);
      ch_q   <= grant_ch_s;
      work_q <= cap_q[grant_ch_s[CHW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          hist_q[c][t] <= 16'd0;
        end
      end
    end else begin
      if (load_en_s) begin
        hist_q[ch_idx_s][wptr_q[ch_idx_s]] <= work_q;
      end
      if (mac_en_s && last_tap_s) begin
        wptr_q[ch_idx_s] <= (wptr_q[ch_idx_s] == TW'(TAPS - 1)) ?
                            '0 : (wptr_q[ch_idx_s] + TW'(1));
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= coef_default(t);
      end
    end else if (coef_wr_s) begin
      coef_q[bus_io.coef_addr[TW-1:0]] <= bus_io.coef_wdata;
    end
  end

  // Tap k reads k samples back from the newest one, modulo the history depth.
  always_comb begin
    if (k_q <= wptr_q[ch_idx_s]) begin
      rd_idx_s = wptr_q[ch_idx_s] - k_q;
    end else begin
      rd_idx_s = wptr_q[ch_idx_s] + TW'(TAPS) - k_q;
    end
    prod_s = 32'(hist_q[ch_idx_s][rd_idx_s]) * 32'(coef_q[k_q]);
  end

  always_comb begin
    acc_d = acc_q;
    k_d   = k_q;
    if (load_en_s) begin
      acc_d = '0;
      k_d   = '0;
    end else if (mac_en_s) begin
      acc_d = acc_q + ACC_W'(prod_s);
      k_d   = last_tap_s ? k_q : (k_q + TW'(1));
    end else begin
      acc_d = acc_q;
      k_d   = k_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      acc_q <= acc_d;
      k_q   <= k_d;
    end
  end

  // Round half-up on bit 15, then clamp to the 16-bit output range.
  always_comb begin
    round_s = RW'(acc_q[ACC_W-1:16]) + RW'(acc_q[15]);
    sat_s   = (|round_s[RW-1:16]) ? 16'hFFFF : round_s[15:0];
  end

  always_comb begin
    out_valid_d = round_en_s;
    if (round_en_s) begin
      out_ch_d   = ch_q;
      out_data_d = sat_s;
    end else begin
      out_ch_d   = out_ch_q;
      out_data_d = out_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= 3'd0;
      out_data_q  <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus_io.coef_ready = coef_ready_s;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.out_ch     = out_ch_q;
  assign bus_io.out_data   = out_data_q;
  assign bus_io.overrun    = overrun_q;
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed-plus-random bench for fir_mac_scheduler; expected samples come from a
// per-channel convolution model over sample-history queues and a coefficient array.
module tb_fir_mac_scheduler;
  localparam int NUM_CH = 2;
  localparam int TAPS   = 10;
  localparam int ACC_W  = 36;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ev_t  evq[$];
  int   coef_m[TAPS];
  int   hist_m[NUM_CH][$];
  int   dflt[TAPS] = '{89, 795, 2665, 5374, 7461, 7461, 5374, 2665, 795, 89};

  fir_mac_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  fir_mac_scheduler #(
    .NUM_CH(NUM_CH),
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b0 && bus.out_valid === 1'b1) begin
      e.ch   = int'(bus.out_ch);
      e.data = int'(bus.out_data);
      e.cyc  = cyc;
      evq.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < TAPS; t++) coef_m[t] = dflt[t];
    for (int c = 0; c < NUM_CH; c++) hist_m[c].delete();
  endtask

  task automatic model_push(input int ch, input int d);
    hist_m[ch].push_front(d);
    if (hist_m[ch].size() > TAPS) void'(hist_m[ch].pop_back());
  endtask

  function automatic int model_out(input int ch);
    longint acc = 0;
    longint r;
    for (int k = 0; k < TAPS; k++) begin
      if (k < hist_m[ch].size()) acc += longint'(hist_m[ch][k]) * longint'(coef_m[k]);
    end
    r = (acc >>> 16) + ((acc >>> 15) & 64'd1);
    return (r > 65535) ? 65535 : int'(r);
  endfunction

  task automatic drive(input logic [1:0] mask, input int d0, input int d1, output int n);
    @(posedge clk); #1;
    bus.in_valid = mask;
    bus.in_data  = {d1[15:0], d0[15:0]};
    n = cyc;
    @(posedge clk); #1;
    bus.in_valid = 2'b00;
  endtask

  task automatic expect_out(input string tag, input int ch, input int data,
                            input int exp_cyc, output int obs);
    int  got;
    ev_t e;
    obs = -1;
    for (int i = 0; i < 400 && evq.size() == 0; i++) @(negedge clk);
    got = (evq.size() != 0) ? 1 : 0;
    chk({tag, "_arrive"}, 64'(got), 64'd1);
    if (got == 1) begin
      e   = evq.pop_front();
      obs = e.data;
      chk({tag, "_ch"}, 64'(e.ch), 64'(ch));
      chk({tag, "_data"}, 64'(e.data), 64'(data));
      if (exp_cyc >= 0) chk({tag, "_latency"}, 64'(e.cyc), 64'(exp_cyc));
    end
  endtask

  task automatic send(input int ch, input int d, input string tag, output int obs);
    int n;
    logic [1:0] m;
    m = (ch == 0) ? 2'b01 : 2'b10;
    drive(m, d, d, n);
    model_push(ch, d);
    expect_out(tag, ch, model_out(ch), n + 14, obs);
  endtask

  task automatic coef_write(input int addr, input int val, input bit accepted);
    @(posedge clk); #1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 5'(addr);
    bus.coef_wdata = 16'(val);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    if (accepted && addr < TAPS) coef_m[addr] = val;
  endtask

  initial begin
    int n;
    int obs;
    int a;
    int b;
    int e0;
    int e1;

    bus.in_valid   = 2'b00;
    bus.in_data    = 32'd0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = 5'd0;
    bus.coef_wdata = 16'd0;
    model_reset();

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    chk("rst_coef_ready", 64'(bus.coef_ready), 64'd1);

    // Impulse on ch0 with default coefficients
    for (int i = 0; i < TAPS; i++) begin
      send(0, (i == 0) ? 65535 : 0, "impulse", obs);
      if (i == 0) chk("impulse_first", 64'(obs), 64'd89);
      if (i == 4) chk("impulse_mid", 64'(obs), 64'd7461);
    end

    // DC on ch1 settles to half scale of the input
    for (int i = 0; i < 12; i++) send(1, 1000, "dc", obs);
    chk("dc_settled", 64'(obs), 64'd500);

    // Simultaneous strobes: ch0 first, then ch1 13 cycles later
    a = int'($urandom_range(65535));
    b = int'($urandom_range(65535));
    drive(2'b11, a, b, n);
    model_push(0, a);
    model_push(1, b);
    e0 = model_out(0);
    e1 = model_out(1);
    expect_out("cont_a0", 0, e0, n + 14, obs);
    expect_out("cont_a1", 1, e1, n + 27, obs);
    send(0, int'($urandom_range(65535)), "cont_single", obs);
    a = int'($urandom_range(65535));
    b = int'($urandom_range(65535));
    drive(2'b11, a, b, n);
    model_push(0, a);
    model_push(1, b);
    e0 = model_out(0);
    e1 = model_out(1);
    expect_out("cont_b1", 1, e1, n + 14, obs);
    expect_out("cont_b0", 0, e0, n + 27, obs);

    // ch0 strobed twice 3 cycles apart while ch1 is in service
    drive(2'b10, 0, 30000, n);
    model_push(1, 30000);
    e1 = model_out(1);
    drive(2'b01, 11111, 0, a);
    @(posedge clk);
    drive(2'b01, 40000, 0, a);
    model_push(0, 40000);
    e0 = model_out(0);
    expect_out("ovr_ch1", 1, e1, n + 14, obs);
    expect_out("ovr_ch0", 0, e0, n + 27, obs);
    chk("ovr_flags", 64'(bus.overrun), 64'd1);

    // Reset on the 5th MAC cycle of a ch0 sample
    drive(2'b01, 12345, 0, n);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_async_data", 64'(bus.out_data), 64'd0);
    chk("midrst_async_overrun", 64'(bus.overrun), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    chk("midrst_no_out", 64'(evq.size()), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("midrst_coef_ready", 64'(bus.coef_ready), 64'd1);
    for (int i = 0; i < TAPS; i++) begin
      send(0, (i == 0) ? 65535 : 0, "impulse2", obs);
      chk("impulse2_tap", 64'(obs), 64'(dflt[i]));
    end

    // Coefficient write during MAC is refused
    drive(2'b01, 5000, 0, n);
    model_push(0, 5000);
    repeat (3) @(posedge clk);
    #1;
    chk("gate_ready_busy", 64'(bus.coef_ready), 64'd0);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 5'd0;
    bus.coef_wdata = 16'd0;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    expect_out("gate_busy", 0, model_out(0), n + 14, obs);

    // Out-of-range address ignored; in-range idle write lands
    coef_write(20, 0, 1'b0);
    coef_write(0, 65535, 1'b1);
    send(1, 1000, "coef_imp", obs);
    chk("coef_imp_first", 64'(obs), 64'd1000);
    send(0, 7777, "coef_range", obs);
    send(1, 0, "coef_imp2", obs);

    // Random coefficients and samples across both channels
    for (int i = 0; i < 6; i++) coef_write(int'($urandom_range(TAPS - 1)), int'($urandom_range(65535)), 1'b1);
    for (int i = 0; i < 14; i++) send(int'($urandom_range(1)), int'($urandom_range(65535)), "rand", obs);

    // Full-scale coefficients and input saturate
    for (int t = 0; t < TAPS; t++) coef_write(t, 65535, 1'b1);
    for (int i = 0; i < TAPS; i++) send(0, 65535, "sat", obs);
    chk("sat_final", 64'(obs), 64'd65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
